// File: rtl/byte_uart_tx.sv
// Byte-stream UART transmitter: a small FIFO fed by valid/ready, then 8-N-1 framing
// with an optional even-parity bit. tx is a flop output and idles high.
module byte_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          parity_en,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic [7:0]    head;

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_lat;
    logic          par_bit;

    logic push, pop, tc, not_empty;

    assign not_empty  = (level != '0);
    assign head       = mem[rd_ptr];
    assign in_ready   = rst_n && (level != LW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign tc         = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    // A pop only happens from registered level, so a byte pushed into an empty FIFO waits one edge.
    assign pop        = ena && not_empty && ((state == IDLE) || (state == STOP && tc));
    assign busy       = (state != IDLE) || not_empty;
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_lat  <= 1'b0;
            par_bit  <= 1'b0;
        end else if (ena) begin
            if (pop) begin
                // Both IDLE and the last STOP cycle load the next frame directly.
                shift    <= head;
                par_lat  <= parity_en;
                par_bit  <= ^head;
                baud_cnt <= '0;
                state    <= START;
                tx       <= 1'b0;
            end else begin
                case (state)
                    START: begin
                        if (tc) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= DATA;
                            tx       <= shift[0];
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    DATA: begin
                        if (tc) begin
                            baud_cnt <= '0;
                            if (bit_idx == 3'd7) begin
                                state <= par_lat ? PARITY : STOP;
                                tx    <= par_lat ? par_bit : 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shift   <= shift >> 1;
                                tx      <= shift[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    PARITY: begin
                        if (tc) begin
                            baud_cnt <= '0;
                            state    <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        if (tc) begin
                            baud_cnt <= '0;
                            state    <= IDLE;
                            tx       <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
